// File: rtl/stopwatch_bcd_if.sv
// Stopwatch command/status bundle: command pulses in, count and display out.
interface stopwatch_bcd_if;
    logic        tick;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        running;
    logic        overflow;
    logic [23:0] disp;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [6:0]  HEX4;
    logic [6:0]  HEX5;

    modport master (
        output tick, start_stop, clear, lap,
        input  running, overflow, disp, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  tick, start_stop, clear, lap,
        output running, overflow, disp, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch mm:ss.cc with run/pause/lap control, sticky overflow on
// wrap from 59:59.99 and six seven-segment digit decoders.
module stopwatch_bcd #(
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input logic            Clock,
    input logic            Reset,
    stopwatch_bcd_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] lap_q, lap_d;
    logic        ovf_q, ovf_d;
    logic        count_en;
    logic        wrap;
    logic [23:0] shown;

    // Active-high segment pattern, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return HEX_ACTIVE_LOW ? ~s : s;
    endfunction

    // Largest legal value of digit i (seconds and minutes tens stop at 5).
    function automatic logic [3:0] digit_max(input int i);
        return (i == 3 || i == 5) ? 4'd5 : 4'd9;
    endfunction

    // Ticks count in RUN/LAP using the current state, so the edge leaving
    // RUN/LAP still counts and the edge entering RUN does not.
    assign count_en = bus.tick && (state_q == StRun || state_q == StLap) && !bus.clear;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next state: clear beats start_stop beats lap.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = StIdle;
        end else if (bus.start_stop) begin
            unique case (state_q)
                StIdle, StPause: state_d = StRun;
                StRun, StLap:    state_d = StPause;
                default:         state_d = StIdle;
            endcase
        end else if (bus.lap) begin
            if (state_q == StRun)      state_d = StLap;
            else if (state_q == StLap) state_d = StRun;
        end
    end

    // Outputs: display selects the lap latch only while frozen.
    always_comb begin
        bus.running  = (state_q == StRun) || (state_q == StLap);
        bus.overflow = ovf_q;
        shown        = (state_q == StLap) ? lap_q : cnt_q;
        bus.disp     = shown;
        bus.HEX0     = seg7(shown[3:0]);
        bus.HEX1     = seg7(shown[7:4]);
        bus.HEX2     = seg7(shown[11:8]);
        bus.HEX3     = seg7(shown[15:12]);
        bus.HEX4     = seg7(shown[19:16]);
        bus.HEX5     = seg7(shown[23:20]);
    end

    // Ripple BCD increment; a carry out of the top digit is the wrap.
    always_comb begin
        logic carry;
        cnt_d = cnt_q;
        carry = count_en;
        if (bus.clear) begin
            cnt_d = '0;
            carry = 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (carry) begin
                    if (cnt_q[4*i +: 4] >= digit_max(i)) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        wrap = carry;
    end

    // Lap latch captures the pre-increment count on RUN->LAP; overflow is sticky.
    always_comb begin
        lap_d = lap_q;
        ovf_d = ovf_q | wrap;
        if (bus.clear) begin
            lap_d = '0;
            ovf_d = 1'b0;
        end else if (!bus.start_stop && bus.lap && state_q == StRun) begin
            lap_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            lap_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lap_q <= lap_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter HEX_ACTIVE_LOW, default 1; 1 = segment lit by driving 0, 0 = segment lit by driving 1.
REQ-002 SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle 1/100 s pulse, e.g. rollover from the upstream mod-k counter.
REQ-005 SHALL have port start_stop  input  1  one-cycle command pulse that toggles run/pause.
REQ-006 SHALL have port clear  input  1  one-cycle command pulse that zeroes the count.
REQ-007 SHALL have port lap  input  1  one-cycle command pulse that freezes or releases the display.
REQ-008 SHALL have port running  output  1  high in RUN or LAP.
REQ-009 SHALL have port overflow  output  1  sticky flag; set on wrap from 59:59.99.
REQ-010 SHALL have port disp  output  24  displayed BCD value {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, 4 bits each.
REQ-011 SHALL have ports HEX0..HEX5  output  7 each  seven-segment codes of disp; HEX0 = cs_u, HEX5 = min_t; bit0=a .. bit6=g.

Function
REQ-012 SHALL implement a 2-bit FSM with states IDLE, RUN, PAUSE and LAP.
REQ-013 SHALL apply command priority clear > start_stop > lap when several commands arrive in one cycle.
REQ-014 clear in any state SHALL go to IDLE, zero the count, zero the lap latch and clear overflow on the next edge.
REQ-015 start_stop SHALL transition: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE (lap freeze released).
REQ-016 lap SHALL transition RUN->LAP, capturing the current count into the lap latch (pre-increment value if tick coincides); LAP->RUN releases.
REQ-017 lap in IDLE or PAUSE SHALL be ignored.
REQ-018 The count SHALL advance by one centisecond on each edge where tick=1 and the current state is RUN or LAP, including the edge that leaves RUN or LAP.
REQ-019 tick on the edge that enters RUN from IDLE or PAUSE SHALL NOT be counted.
REQ-020 Digit rollover: cs_u 9->0 carries to cs_t; cs_t 9->0 carries to sec_u; sec 59->00 carries to min; min 59->00 wraps the whole count to 00:00.00.
REQ-021 On the wrap edge, overflow SHALL be set and remain set until clear or Reset; counting SHALL continue.
REQ-022 Every BCD digit register SHALL hold only legal values (units 0-9, tens 0-5 for sec/min, 0-9 for cs_t).
REQ-023 disp SHALL equal the lap latch in LAP and the live count in all other states; combinational from registers, zero added latency.
REQ-024 HEX0..HEX5 SHALL be combinational decodes of disp; patterns 0-9 standard, codes A-F never occur; output inverted when HEX_ACTIVE_LOW=1.
REQ-025 The count SHALL update on the same edge that samples tick; disp/HEX SHALL reflect it in that cycle.
REQ-026 clear coinciding with tick SHALL yield count 00:00.00 (clear wins).

Reset
REQ-027 Reset=1 SHALL asynchronously force state IDLE, count and lap latch 0, overflow 0, running 0.
REQ-028 During Reset, HEX0..HEX5 SHALL show "0" (7'b1000000 when HEX_ACTIVE_LOW=1); Reset mid-RUN or mid-LAP SHALL discard all state without waiting for a clock edge.
REQ-029 After Reset deasserts, the first edge SHALL be processed normally; commands on that edge SHALL be honoured.

Verification
REQ-030 Reset, start_stop, 100 ticks -> disp=00:01.00, running=1, HEX0..HEX3 = 0,0,1,0 (active-low codes).
REQ-031 Preload to 00:59.99 via ticks, 1 more tick -> disp=01:00.00; from 59:59.99, 1 tick -> 00:00.00, overflow=1 and sticky across 5 further ticks.
REQ-032 RUN at 00:00.42, lap -> disp frozen at 00:00.42 while 30 ticks run; lap again -> disp=00:00.72.
REQ-033 RUN, start_stop and tick same cycle -> tick counted, PAUSE; ticks in PAUSE ignored; start_stop+tick from PAUSE -> tick not counted.
REQ-034 clear+start_stop+lap+tick same cycle in LAP -> IDLE, disp=00:00.00, overflow=0, running=0.
REQ-035 Reset asserted mid-RUN between clock edges -> outputs zero/IDLE immediately, before the next edge.
